// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int AW_DEF       = 10;
  localparam int DW_DEF       = 32;
  localparam int LOCK_MAX_DEF = 16;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_lock_timer.sv
// Lock-duration counter for port B: counts cycles spent in LOCKED,
// flags the terminal count, and holds off re-locking after a forced break
// until lock_b has been seen low.
module lock_timer
  import mem_arb_pkg::*;
#(
  parameter int LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_run,
  input  logic i_lock,
  output logic o_tc,
  output logic o_rearm_block,
  output logic o_timeout
);

  localparam int            CW     = cnt_width(LOCK_MAX);
  localparam logic [CW-1:0] TC_VAL = CW'(LOCK_MAX - 1);

  logic [CW-1:0] r_cnt;
  logic          r_block;
  logic          r_timeout;
  logic          w_tc;
  logic          w_break;

  assign w_tc    = i_run && (r_cnt == TC_VAL);
  assign w_break = w_tc && i_lock;

  // Lock counter: cleared on lock entry, advances every LOCKED cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
    end else if (i_run) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Rearm flag: set by a forced break, cleared once lock_b drops.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_block <= 1'b0;
    end else if (w_break) begin
      r_block <= 1'b1;
    end else if (!i_lock) begin
      r_block <= 1'b0;
    end
  end

  // Timeout pulse: high for the single cycle following a forced break.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_break;
    end
  end

  assign o_tc          = w_tc;
  assign o_rearm_block = r_block;
  assign o_timeout     = r_timeout;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port RAM with 1-cycle read latency.
// Round-robin between A and B, with an optional time-limited exclusive lock
// for port B. Grants are combinational so a single requester can issue
// every cycle.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          req_a,
  input  logic          we_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] wdata_a,
  output logic          gnt_a,
  output logic          rvalid_a,
  output logic [DW-1:0] rdata_a,
  input  logic          req_b,
  input  logic          we_b,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] wdata_b,
  output logic          gnt_b,
  output logic          rvalid_b,
  output logic [DW-1:0] rdata_b,
  input  logic          lock_b,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          lock_timeout
);

  arb_state_e r_state;
  arb_state_e w_state_nxt;
  port_e      r_last;
  port_e      w_last_nxt;

  logic w_gnt_a;
  logic w_gnt_b;
  logic w_lock_enter;
  logic w_tc;
  logic w_rearm_block;
  logic w_timeout_q;
  logic r_rvalid_a_p1;
  logic r_rvalid_b_p1;

  // A B grant in ARB with lock_b set takes the lock unless a forced break
  // is still waiting for lock_b to drop.
  assign w_lock_enter = (r_state == ARB) && w_gnt_b && lock_b && !w_rearm_block;

  lock_timer #(
    .LOCK_MAX(LOCK_MAX)
  ) u_lock_timer (
    .i_clk        (CLK),
    .i_rst        (RST),
    .i_load       (w_lock_enter),
    .i_run        (r_state == LOCKED),
    .i_lock       (lock_b),
    .o_tc         (w_tc),
    .o_rearm_block(w_rearm_block),
    .o_timeout    (w_timeout_q)
  );

  // State and priority pointer registers; pointer resets to B so A wins first.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ARB;
      r_last  <= PORT_B;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // Next state and pointer: pointer follows grants, and any LOCKED cycle
  // leaves it at B so A has priority once the lock ends.
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    case (r_state)
      ARB: begin
        if (w_gnt_a) begin
          w_last_nxt = PORT_A;
        end else if (w_gnt_b) begin
          w_last_nxt = PORT_B;
        end
        if (w_lock_enter) begin
          w_state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        w_last_nxt = PORT_B;
        if (!lock_b || w_tc) begin
          w_state_nxt = ARB;
        end
      end
      default: begin
        w_state_nxt = ARB;
        w_last_nxt  = PORT_B;
      end
    endcase
  end

  // Grant decode: round-robin in ARB, B only in LOCKED, nothing during reset.
  always_comb begin
    w_gnt_a = 1'b0;
    w_gnt_b = 1'b0;
    if (!RST) begin
      case (r_state)
        ARB: begin
          if (req_a && req_b) begin
            w_gnt_a = (r_last == PORT_B);
            w_gnt_b = (r_last == PORT_A);
          end else begin
            w_gnt_a = req_a;
            w_gnt_b = req_b;
          end
        end
        LOCKED: begin
          w_gnt_b = req_b;
        end
        default: begin
          w_gnt_a = 1'b0;
          w_gnt_b = 1'b0;
        end
      endcase
    end
  end

  // RAM command mux: pass the granted port through, idle bus is all zero.
  always_comb begin
    mem_en    = w_gnt_a || w_gnt_b;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_gnt_a) begin
      mem_we    = we_a;
      mem_addr  = addr_a;
      mem_wdata = wdata_a;
    end else if (w_gnt_b) begin
      mem_we    = we_b;
      mem_addr  = addr_b;
      mem_wdata = wdata_b;
    end
  end

  // Read-return stage: a read grant becomes rvalid one cycle later,
  // aligned with the RAM's registered output.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rvalid_a_p1 <= 1'b0;
      r_rvalid_b_p1 <= 1'b0;
    end else begin
      r_rvalid_a_p1 <= w_gnt_a && !we_a;
      r_rvalid_b_p1 <= w_gnt_b && !we_b;
    end
  end

  // Registered status is masked by RST so a read granted just before reset
  // cannot show up while reset is held.
  assign gnt_a        = w_gnt_a;
  assign gnt_b        = w_gnt_b;
  assign rvalid_a     = r_rvalid_a_p1 && !RST;
  assign rvalid_b     = r_rvalid_b_p1 && !RST;
  assign rdata_a      = rvalid_a ? mem_rdata : '0;
  assign rdata_b      = rvalid_b ? mem_rdata : '0;
  assign lock_timeout = w_timeout_q && !RST;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a behavioural reference of the arbiter.
module tb_mem_arbiter;

  localparam int AW       = 10;
  localparam int DW       = 32;
  localparam int LOCK_MAX = 16;

  logic          CLK;
  logic          RST;
  logic          req_a, we_a, req_b, we_b, lock_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] wdata_a, wdata_b;
  logic          gnt_a, rvalid_a, gnt_b, rvalid_b;
  logic [DW-1:0] rdata_a, rdata_b;
  logic          mem_en, mem_we, lock_timeout;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  mem_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
    .CLK(CLK), .RST(RST),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
    .lock_b(lock_b),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .lock_timeout(lock_timeout)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Reference model state: what the arbiter is doing, in plain terms.
  bit m_locked;     // B currently owns the RAM
  bit m_a_next;     // on contention, A wins
  int m_lock_age;   // cycles B has held the lock so far
  bit m_must_drop;  // lock was broken; lock_b must fall before relocking
  bit m_rd_a, m_rd_b; // read accepted last cycle
  bit m_to;         // lock broken last cycle

  // Values seen at the last sample point, for scenario-level checks.
  logic          o_ga, o_gb, o_rva, o_to;
  logic [DW-1:0] o_rda;
  logic [AW-1:0] o_addr;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_locked    = 0;
    m_a_next    = 1;
    m_lock_age  = 0;
    m_must_drop = 0;
    m_rd_a      = 0;
    m_rd_b      = 0;
    m_to        = 0;
  endtask

  // One clock: sample at the falling edge, compare, advance the model,
  // then return just after the rising edge so new inputs can be applied.
  task automatic cycle();
    bit e_ga, e_gb, e_rva, e_rvb, e_to, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    @(negedge CLK);
    if (RST) begin
      e_ga = 0; e_gb = 0; e_rva = 0; e_rvb = 0; e_to = 0;
    end else begin
      if (m_locked) begin
        e_ga = 0;
        e_gb = req_b;
      end else if (req_a && req_b) begin
        e_ga = m_a_next;
        e_gb = !m_a_next;
      end else begin
        e_ga = req_a;
        e_gb = req_b;
      end
      e_rva = m_rd_a;
      e_rvb = m_rd_b;
      e_to  = m_to;
    end
    e_we   = e_ga ? we_a    : (e_gb ? we_b    : 1'b0);
    e_addr = e_ga ? addr_a  : (e_gb ? addr_b  : '0);
    e_wd   = e_ga ? wdata_a : (e_gb ? wdata_b : '0);

    chk("gnt_a", DW'(gnt_a), DW'(e_ga));
    chk("gnt_b", DW'(gnt_b), DW'(e_gb));
    chk("mem_en", DW'(mem_en), DW'(e_ga | e_gb));
    chk("mem_we", DW'(mem_we), DW'(e_we));
    chk("mem_addr", DW'(mem_addr), DW'(e_addr));
    chk("mem_wdata", mem_wdata, e_wd);
    chk("rvalid_a", DW'(rvalid_a), DW'(e_rva));
    chk("rvalid_b", DW'(rvalid_b), DW'(e_rvb));
    chk("rdata_a", rdata_a, e_rva ? mem_rdata : '0);
    chk("rdata_b", rdata_b, e_rvb ? mem_rdata : '0);
    chk("lock_timeout", DW'(lock_timeout), DW'(e_to));

    o_ga = gnt_a; o_gb = gnt_b; o_rva = rvalid_a; o_rda = rdata_a;
    o_to = lock_timeout; o_addr = mem_addr;

    if (RST) begin
      model_reset();
    end else begin
      m_rd_a = e_ga && !we_a;
      m_rd_b = e_gb && !we_b;
      m_to   = 0;
      if (m_locked) begin
        m_a_next = 1;
        if (!lock_b) begin
          m_locked = 0;
        end else if (m_lock_age == LOCK_MAX - 1) begin
          m_locked    = 0;
          m_to        = 1;
          m_must_drop = 1;
        end else begin
          m_lock_age++;
        end
      end else begin
        if (e_ga) m_a_next = 0;
        if (e_gb) m_a_next = 1;
        if (e_gb && lock_b && !m_must_drop) begin
          m_locked   = 1;
          m_lock_age = 0;
        end
      end
      if (!lock_b) m_must_drop = 0;
    end
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    req_a = 0; we_a = 0; addr_a = '0; wdata_a = '0;
    req_b = 0; we_b = 0; addr_b = '0; wdata_b = '0;
    lock_b = 0;
  endtask

  logic          ga_hist [20];
  int            n_to, to_at;
  logic [DW-1:0] seq;

  initial begin
    idle_inputs();
    mem_rdata = '0;
    RST = 1;
    model_reset();
    repeat (3) cycle();
    chk("reset_gnt_a", DW'(o_ga), '0);
    RST = 0;

    // Single read from A: grant now, data one cycle later.
    req_a = 1; we_a = 0; addr_a = 10'd5; mem_rdata = 32'h1234_5678;
    cycle();
    chk("s1_gnt_a", DW'(o_ga), 32'd1);
    chk("s1_addr", DW'(o_addr), 32'd5);
    req_a = 0; mem_rdata = 32'hDEAD_BEEF;
    cycle();
    chk("s1_rvalid_a", DW'(o_rva), 32'd1);
    chk("s1_rdata_a", o_rda, 32'hDEAD_BEEF);

    // Contention straight after reset alternates A,B,A,B.
    RST = 1; cycle(); RST = 0;
    req_a = 1; req_b = 1; addr_a = 10'd1; addr_b = 10'd2;
    seq = '0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      seq = {seq[DW-3:0], o_ga, o_gb};
    end
    chk("s2_order", seq, 32'b10_01_10_01);

    // B takes the lock with a write; A is locked out until lock_b drops.
    req_a = 0; req_b = 1; we_b = 1; lock_b = 1; wdata_b = 32'hCAFE_0001;
    cycle();
    chk("s3_gnt_b_lock", DW'(o_gb), 32'd1);
    req_a = 1; we_b = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("s3_gnt_a_locked", DW'(o_ga), 32'd0);
    end
    lock_b = 0;
    cycle();
    chk("s3_exit_cycle_gnt_a", DW'(o_ga), 32'd0);
    cycle();
    chk("s3_a_first_after_exit", DW'(o_ga), 32'd1);

    // Lock held too long: forced break after LOCK_MAX cycles, no relock.
    lock_b = 1; req_a = 1; req_b = 1; we_b = 1;
    n_to = 0; to_at = -1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      ga_hist[i] = o_ga;
      if (o_to === 1'b1) begin
        n_to++;
        if (to_at < 0) to_at = i;
      end
    end
    chk("s4_timeout_count", DW'(n_to), 32'd1);
    chk("s4_timeout_at", DW'(to_at), 32'd17);
    chk("s4_gnt_a_in_lock", DW'(ga_hist[8]), 32'd0);
    chk("s4_gnt_a_after_break", DW'(ga_hist[17]), 32'd1);
    chk("s4_no_relock", DW'(ga_hist[19]), 32'd1);
    idle_inputs();
    cycle();

    // Read granted right before reset must not surface afterwards.
    req_a = 1; we_a = 0; addr_a = 10'd9;
    cycle();
    chk("s5_gnt_a", DW'(o_ga), 32'd1);
    RST = 1; req_a = 0; mem_rdata = 32'hFFFF_FFFF;
    cycle();
    chk("s5_rvalid_in_reset", DW'(o_rva), 32'd0);
    cycle();
    RST = 0;
    cycle();
    chk("s5_rvalid_after_reset", DW'(o_rva), 32'd0);

    // Random traffic, occasional reset, sticky lock_b.
    for (int i = 0; i < 600; i++) begin
      req_a   = ($urandom_range(0, 9) < 7);
      req_b   = ($urandom_range(0, 9) < 7);
      we_a    = $urandom_range(0, 1);
      we_b    = $urandom_range(0, 1);
      addr_a  = AW'($urandom);
      addr_b  = AW'($urandom);
      wdata_a = $urandom;
      wdata_b = $urandom;
      mem_rdata = $urandom;
      if ($urandom_range(0, 7) == 0) lock_b = !lock_b;
      RST = ($urandom_range(0, 59) == 0);
      cycle();
    end
    RST = 0;
    idle_inputs();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
